serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial unsigned binary subtractor computing A − B − Bin over WIDTH clock cycles using a single full-subtractor cell and a registered borrow. It is the subtracting counterpart of the ripple-carry binary adder in the arithmetic library. It trades latency for area and provides a start/busy/done handshake so a controller can sequence operations.

## Interface
- WIDTH, 4, operand and result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- A  input  WIDTH  minuend; captured on accepted start
- B  input  WIDTH  subtrahend; captured on accepted start
- Bin  input  1  borrow-in; captured on accepted start
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse; result valid
- diff  output  WIDTH  (A − B − Bin) mod 2^WIDTH
- Bout  output  1  borrow-out; 1 iff A < B + Bin (unsigned)

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE with start=1:
  - load shift registers a_sr←A, b_sr←B, diff_sr←0;
  - borrow register br←Bin, bit counter cnt←0;
  - go to SHIFT.
- IDLE with start=0: stay in IDLE.
- SHIFT, each cycle:
  - d = a_sr[0] ^ b_sr[0] ^ br
  - br ← (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br)
  - diff_sr ← {d, diff_sr[WIDTH-1:1]}; a_sr and b_sr shift right by 1
  - cnt ← cnt+1
  - after the WIDTH-th bit (cnt = WIDTH−1 at the edge), go to DONE.
- DONE, one cycle:
  - diff ← final diff_sr, Bout ← final br, both loaded on entry;
  - then go to IDLE.
- diff and Bout are a separate result register. They change only on entry to DONE and hold their value through later IDLE/SHIFT periods until the next completion.
- start is ignored in SHIFT and DONE: no queuing, and no effect on operands in flight.
- A, B and Bin may change freely after the accepting edge.
- cnt width is clog2(WIDTH), with no wrap-around beyond WIDTH−1.

## Timing
- Reset (rst=1 at an edge):
  - state→IDLE; busy=0, done=0, diff=0, Bout=0;
  - internal shift registers, br and cnt cleared.
- Reset mid-operation aborts immediately. No done pulse is produced, and the result register is cleared to 0.
- rst has priority over start in the same cycle.
- For start accepted at edge k:
  - busy=1 from after edge k through after edge k+WIDTH−1 (WIDTH cycles);
  - done=1 for exactly the cycle after edge k+WIDTH, with diff/Bout valid in that same cycle;
  - busy=0 while done=1.
- Earliest next accept is edge k+WIDTH+2, which gives a throughput of one operation per WIDTH+2 cycles.
- busy and done are registered outputs (decoded from the state register); there are no combinational paths from inputs to outputs.

## Test plan
- Reset check, WIDTH=4: rst for 2 cycles → busy=0, done=0, diff=0, Bout=0; with start=0 the outputs stay unchanged.
- Basic, WIDTH=4: A=9, B=3, Bin=0, start at edge k → done only in the cycle after edge k+4, diff=6, Bout=0; busy high for exactly 4 cycles.
- Borrow out: A=3, B=9, Bin=0 → diff=10 (4'b1010), Bout=1.
- Borrow-in boundaries:
  - A=0, B=0, Bin=1 → diff=15, Bout=1;
  - A=7, B=7, Bin=0 → diff=0, Bout=0;
  - A=15, B=0, Bin=0 → diff=15, Bout=0.
- Ignored start and operand change:
  - start pulsed while busy and during DONE, with A/B changed after the accept → result matches the originally captured operands, and exactly one done pulse.
- Reset mid-operation and exhaustive sweep:
  - rst at the 2nd busy cycle → no done, outputs 0, the next start computes correctly;
  - then all 512 combinations of A, B and Bin against a reference model → diff and Bout match every time.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The master issues operations and the slave computes them.
interface serial_subtractor_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;

   modport master (
      output start, a, b, bin,
      input  busy, done, diff, bout
   );

   modport slave (
      input  start, a, b, bin,
      output busy, done, diff, bout
   );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell with a registered borrow,
// computing a - b - bin LSB first over WIDTH cycles behind a start/busy/done handshake.
//
//   state | meaning
//   IDLE  | waiting for start; operands are captured on the accepting edge
//   SHIFT | one bit per cycle, WIDTH cycles, busy high
//   DONE  | one-cycle done pulse; result register was loaded on entry
module serial_subtractor #(
   parameter int WIDTH = 4
) (
   input logic                clk,
   input logic                rst,
   serial_subtractor_if.slave sub
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] diff_sr;
   logic [WIDTH-1:0] diff_q;
   logic             br;
   logic             bout_q;
   logic [CW-1:0]    cnt;
   logic             d_bit;
   logic             br_next;
   logic             last_bit;

   always_comb begin
      d_bit    = a_sr[0] ^ b_sr[0] ^ br;
      br_next  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
      last_bit = (cnt == CW'(WIDTH - 1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (sub.start) state_d = SHIFT;
         SHIFT:   if (last_bit) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_sr    <= '0;
         b_sr    <= '0;
         diff_sr <= '0;
         br      <= 1'b0;
         cnt     <= '0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (sub.start) begin
                  a_sr    <= sub.a;
                  b_sr    <= sub.b;
                  diff_sr <= '0;
                  br      <= sub.bin;
                  cnt     <= '0;
               end
            end
            SHIFT: begin
               a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
               b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
               diff_sr <= {d_bit, diff_sr[WIDTH-1:1]};
               br      <= br_next;
               // Result register only moves on the final bit, so it holds across later operations.
               if (last_bit) begin
                  cnt    <= '0;
                  diff_q <= {d_bit, diff_sr[WIDTH-1:1]};
                  bout_q <= br_next;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign sub.busy = (state_q == SHIFT);
   assign sub.done = (state_q == DONE);
   assign sub.diff = diff_q;
   assign sub.bout = bout_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor against an arithmetic reference model.
module tb_serial_subtractor;
   localparam int WIDTH = 4;
   localparam int MOD   = 1 << WIDTH;

   logic clk = 1'b0;
   logic rst;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   serial_subtractor_if #(.WIDTH(WIDTH)) sub ();

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .sub (sub)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void ref_sub(input int a, input int b, input int bin,
                                   output logic [WIDTH-1:0] d, output logic bo);
      int r;
      r  = a - b - bin;
      bo = (r < 0);
      d  = WIDTH'(r + MOD);
   endfunction

   // Issues one operation from the current (post-edge) time and waits for done with a bound.
   // Returns in the cycle after the done pulse, when the DUT is back in IDLE.
   task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin,
                        input bit poke, output logic [WIDTH-1:0] rd, output logic rb,
                        output int lat, output int busy_cnt, output int extra_done);
      sub.a     = a;
      sub.b     = b;
      sub.bin   = bin;
      sub.start = 1'b1;
      tick();
      sub.start = 1'b0;
      sub.a     = WIDTH'($urandom);
      sub.b     = WIDTH'($urandom);
      sub.bin   = 1'($urandom);
      lat = -1; busy_cnt = 0; extra_done = 0; rd = '0; rb = 1'b0;
      for (int n = 0; n < 4 * WIDTH; n++) begin
         if (sub.busy) busy_cnt++;
         if (sub.done) begin
            lat = n;
            rd  = sub.diff;
            rb  = sub.bout;
            break;
         end
         if (poke && n == 1) begin
            sub.start = 1'b1;
            sub.a     = WIDTH'($urandom);
            sub.b     = WIDTH'($urandom);
            sub.bin   = 1'($urandom);
         end else begin
            sub.start = 1'b0;
         end
         tick();
      end
      if (lat >= 0) begin
         sub.start = poke;
         tick();
         sub.start = 1'b0;
         if (sub.done) extra_done++;
         if (poke) begin
            for (int i = 0; i < 2 * WIDTH; i++) begin
               tick();
               if (sub.done) extra_done++;
            end
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      sub.start = 1'b0; sub.a = '0; sub.b = '0; sub.bin = 1'b0;
      tick();
      tick();
      tests++; if (sub.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b, expected 0", sub.busy); end
      tests++; if (sub.done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b, expected 0", sub.done); end
      tests++; if (sub.diff !== '0) begin fails++; $display("FAIL reset_diff: got %0d, expected 0", sub.diff); end
      tests++; if (sub.bout !== 1'b0) begin fails++; $display("FAIL reset_bout: got %b, expected 0", sub.bout); end
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         tests++;
         if ({sub.busy, sub.done, sub.bout} !== 3'b000 || sub.diff !== '0) begin
            fails++;
            $display("FAIL idle_hold: got busy=%b done=%b diff=%0d bout=%b, expected all 0",
                     sub.busy, sub.done, sub.diff, sub.bout);
         end
      end
   endtask

   task automatic test_basic();
      logic [WIDTH-1:0] rd; logic rb; int lat, bc, xd;
      do_op(4'd9, 4'd3, 1'b0, 1'b0, rd, rb, lat, bc, xd);
      tests++; if (lat !== WIDTH) begin fails++; $display("FAIL basic_latency: got %0d, expected %0d", lat, WIDTH); end
      tests++; if (bc !== WIDTH) begin fails++; $display("FAIL basic_busy_cycles: got %0d, expected %0d", bc, WIDTH); end
      tests++; if (rd !== 4'd6) begin fails++; $display("FAIL basic_diff: got %0d, expected 6", rd); end
      tests++; if (rb !== 1'b0) begin fails++; $display("FAIL basic_bout: got %b, expected 0", rb); end
      tests++; if (xd !== 0) begin fails++; $display("FAIL basic_done_width: got %0d extra, expected 0", xd); end
   endtask

   task automatic test_borrow();
      logic [WIDTH-1:0] rd; logic rb; int lat, bc, xd;
      do_op(4'd3, 4'd9, 1'b0, 1'b0, rd, rb, lat, bc, xd);
      tests++; if (rd !== 4'd10) begin fails++; $display("FAIL borrow_diff: got %0d, expected 10", rd); end
      tests++; if (rb !== 1'b1) begin fails++; $display("FAIL borrow_bout: got %b, expected 1", rb); end
   endtask

   task automatic test_boundaries();
      logic [WIDTH-1:0] ta [3] = '{4'd0, 4'd7, 4'd15};
      logic [WIDTH-1:0] tb_ [3] = '{4'd0, 4'd7, 4'd0};
      logic             tbi [3] = '{1'b1, 1'b0, 1'b0};
      logic [WIDTH-1:0] ed [3] = '{4'd15, 4'd0, 4'd15};
      logic             eb [3] = '{1'b1, 1'b0, 1'b0};
      logic [WIDTH-1:0] rd; logic rb; int lat, bc, xd;
      for (int i = 0; i < 3; i++) begin
         do_op(ta[i], tb_[i], tbi[i], 1'b0, rd, rb, lat, bc, xd);
         tests++; if (rd !== ed[i]) begin fails++; $display("FAIL boundary_diff[%0d]: got %0d, expected %0d", i, rd, ed[i]); end
         tests++; if (rb !== eb[i]) begin fails++; $display("FAIL boundary_bout[%0d]: got %b, expected %b", i, rb, eb[i]); end
      end
   endtask

   task automatic test_ignored_start();
      logic [WIDTH-1:0] rd, ed; logic rb, eb; int lat, bc, xd;
      ref_sub(5, 12, 1, ed, eb);
      do_op(4'd5, 4'd12, 1'b1, 1'b1, rd, rb, lat, bc, xd);
      tests++; if (rd !== ed) begin fails++; $display("FAIL ignored_start_diff: got %0d, expected %0d", rd, ed); end
      tests++; if (rb !== eb) begin fails++; $display("FAIL ignored_start_bout: got %b, expected %b", rb, eb); end
      tests++; if (lat !== WIDTH) begin fails++; $display("FAIL ignored_start_latency: got %0d, expected %0d", lat, WIDTH); end
      tests++; if (xd !== 0) begin fails++; $display("FAIL ignored_start_done_count: got %0d extra, expected 0", xd); end
   endtask

   task automatic test_reset_mid();
      logic [WIDTH-1:0] rd; logic rb; int lat, bc, xd, nd;
      do_op(4'd13, 4'd2, 1'b0, 1'b0, rd, rb, lat, bc, xd);
      tests++; if (rd !== 4'd11) begin fails++; $display("FAIL pre_abort_diff: got %0d, expected 11", rd); end
      sub.a = 4'd6; sub.b = 4'd1; sub.bin = 1'b0; sub.start = 1'b1;
      tick();
      sub.start = 1'b0;
      tick();
      tests++; if (sub.busy !== 1'b1) begin fails++; $display("FAIL mid_busy: got %b, expected 1", sub.busy); end
      tests++; if (sub.diff !== 4'd11) begin fails++; $display("FAIL result_hold: got %0d, expected 11", sub.diff); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tests++;
      if ({sub.busy, sub.done, sub.bout} !== 3'b000 || sub.diff !== '0) begin
         fails++;
         $display("FAIL abort_clear: got busy=%b done=%b diff=%0d bout=%b, expected all 0",
                  sub.busy, sub.done, sub.diff, sub.bout);
      end
      nd = 0;
      for (int i = 0; i < 2 * WIDTH; i++) begin
         tick();
         if (sub.done) nd++;
      end
      tests++; if (nd !== 0) begin fails++; $display("FAIL abort_no_done: got %0d pulses, expected 0", nd); end
      do_op(4'd6, 4'd1, 1'b0, 1'b0, rd, rb, lat, bc, xd);
      tests++; if (rd !== 4'd5 || rb !== 1'b0) begin fails++; $display("FAIL post_abort: got diff=%0d bout=%b, expected diff=5 bout=0", rd, rb); end
      tests++; if (lat !== WIDTH) begin fails++; $display("FAIL post_abort_latency: got %0d, expected %0d", lat, WIDTH); end
   endtask

   task automatic test_back_to_back();
      logic [WIDTH-1:0] a, b, rd, ed; logic bin, rb, eb; int lat, bc, xd;
      for (int i = 0; i < 12; i++) begin
         a = WIDTH'($urandom); b = WIDTH'($urandom); bin = 1'($urandom);
         ref_sub(int'(a), int'(b), int'(bin), ed, eb);
         do_op(a, b, bin, 1'b0, rd, rb, lat, bc, xd);
         tests++;
         if (rd !== ed || rb !== eb || lat !== WIDTH) begin
            fails++;
            $display("FAIL back_to_back[%0d]: got diff=%0d bout=%b lat=%0d, expected diff=%0d bout=%b lat=%0d",
                     i, rd, rb, lat, ed, eb, WIDTH);
         end
      end
   endtask

   task automatic test_exhaustive();
      logic [WIDTH-1:0] rd, ed; logic rb, eb; int lat, bc, xd;
      for (int a = 0; a < MOD; a++) begin
         for (int b = 0; b < MOD; b++) begin
            for (int bin = 0; bin < 2; bin++) begin
               ref_sub(a, b, bin, ed, eb);
               do_op(WIDTH'(a), WIDTH'(b), 1'(bin), 1'b0, rd, rb, lat, bc, xd);
               tests++;
               if (rd !== ed || rb !== eb || lat !== WIDTH || bc !== WIDTH) begin
                  fails++;
                  $display("FAIL sweep a=%0d b=%0d bin=%0d: got diff=%0d bout=%b lat=%0d busy=%0d, expected diff=%0d bout=%b lat=%0d busy=%0d",
                           a, b, bin, rd, rb, lat, bc, ed, eb, WIDTH, WIDTH);
               end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_borrow();
      test_boundaries();
      test_ignored_start();
      test_reset_mid();
      test_back_to_back();
      test_exhaustive();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
